// File: rtl/tx_redundant_framer.sv
// rtl/tx_redundant_framer.sv - redundant Ethernet frame transmitter with sequence/copy stamping
module tx_redundant_framer #(
  parameter int REDUNDANCY = 3,
  parameter int ID_POS     = 25,
  parameter int MAX_LEN    = 1514,
  parameter int IFG_BYTES  = 12
) (
  input  logic        clk125MHz,
  input  logic        rst,
  input  logic        adv_data,
  input  logic        start,
  input  logic [10:0] pl_len,
  output logic [10:0] pl_addr,
  input  logic [7:0]  pl_data,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  output logic        busy,
  output logic        done,
  output logic [7:0]  seq
);

  typedef enum logic [2:0] {IDLE, PRE, SFD, PAY, PAD, FCS, IFG} state_t;

  state_t      state, state_nx;
  logic [10:0] len, off, cnt, len_clamp;
  logic [2:0]  copy;
  logic [31:0] crc;
  logic [7:0]  byte_nx;
  logic        en_nx, ifg_last, last_copy;

  // Payload prefetch: the buffer answers one cycle after the address, so a
  // short queue keeps full-rate PAY fed while the address runs ahead.
  logic [7:0]  pf_mem [4];
  logic [1:0]  pf_wr, pf_rd;
  logic [2:0]  pf_cnt;
  logic        pf_inflight, pf_issue, pf_pop;

  assign len_clamp = (pl_len > 11'(MAX_LEN)) ? 11'(MAX_LEN) : pl_len;
  assign ifg_last  = (cnt == 11'(IFG_BYTES - 1));
  assign last_copy = (copy == 3'(REDUNDANCY - 1));
  assign pf_pop    = adv_data && (state == PAY);
  assign pf_issue  = ((state == PRE) || (state == SFD) || (state == PAY)) &&
                     (pl_addr < len) && ((pf_cnt + {2'b0, pf_inflight}) < 3'd3);

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // State register
  always_ff @(posedge clk125MHz) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state: start is taken on any cycle, everything else moves on adv slots
  always_comb begin
    state_nx = state;
    if (state == IDLE) begin
      if (start) state_nx = PRE;
    end else if (adv_data) begin
      case (state)
        PRE: if (cnt == 11'd6) state_nx = SFD;
        SFD: state_nx = (len == 11'd0) ? PAD : PAY;
        PAY: if (off == len - 11'd1) state_nx = (len < 11'd60) ? PAD : FCS;
        PAD: if (off == 11'd59) state_nx = FCS;
        FCS: if (cnt == 11'd3) state_nx = IFG;
        IFG: if (ifg_last) state_nx = last_copy ? IDLE : PRE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Output byte for the current slot, stamps overriding payload or pad
  always_comb begin
    byte_nx = 8'h00;
    en_nx   = 1'b0;
    case (state)
      PRE: begin byte_nx = 8'h55; en_nx = 1'b1; end
      SFD: begin byte_nx = 8'hD5; en_nx = 1'b1; end
      PAY, PAD: begin
        en_nx = 1'b1;
        if (off == 11'(ID_POS))          byte_nx = seq;
        else if (off == 11'(ID_POS + 1)) byte_nx = {5'b0, copy};
        else if (state == PAY)           byte_nx = pf_mem[pf_rd];
      end
      FCS: begin byte_nx = ~crc[8*cnt[1:0] +: 8]; en_nx = 1'b1; end
      default: ;
    endcase
  end

  // Prefetch queue storage
  always_ff @(posedge clk125MHz) begin
    if (pf_inflight) pf_mem[pf_wr] <= pl_data;
  end

  // Prefetch pointers and buffer address
  always_ff @(posedge clk125MHz) begin
    if (rst) begin
      pf_wr <= '0; pf_rd <= '0; pf_cnt <= '0; pf_inflight <= 1'b0; pl_addr <= '0;
    end else begin
      pf_inflight <= pf_issue;
      if (pf_issue) pl_addr <= pl_addr + 11'd1;
      else if (adv_data && (state == IFG) && ifg_last) pl_addr <= '0;
      if (pf_inflight) pf_wr <= pf_wr + 2'd1;
      if (pf_pop) pf_rd <= pf_rd + 2'd1;
      pf_cnt <= pf_cnt + {2'b0, pf_inflight} - {2'b0, pf_pop};
    end
  end

  // Frame datapath: counters, CRC, registered outputs, burst bookkeeping
  always_ff @(posedge clk125MHz) begin
    if (rst) begin
      tx_data <= '0; tx_en <= 1'b0; busy <= 1'b0; done <= 1'b0; seq <= '0;
      copy <= '0; len <= '0; off <= '0; cnt <= '0; crc <= 32'hFFFFFFFF;
    end else begin
      done <= 1'b0;
      if ((state == IDLE) && start) begin
        len  <= len_clamp;
        busy <= 1'b1;
      end
      if (state_nx != state) cnt <= '0;
      else if (adv_data)     cnt <= cnt + 11'd1;
      if (adv_data && (state != IDLE)) begin
        tx_data <= byte_nx;
        tx_en   <= en_nx;
        case (state)
          SFD: begin off <= '0; crc <= 32'hFFFFFFFF; end
          PAY, PAD: begin off <= off + 11'd1; crc <= crc_upd(crc, byte_nx); end
          IFG: if (ifg_last) begin
            if (last_copy) begin
              done <= 1'b1; seq <= seq + 8'd1; copy <= '0; busy <= 1'b0;
            end else begin
              copy <= copy + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/tx_redundant_framer.md
Name: tx_redundant_framer

Overview:
- Transmit-side counterpart of the receive chain (preamble strip, CRC strip, majority vote, log).
- Reads a payload by address from a caller-owned buffer. Sends it as REDUNDANCY back-to-back Ethernet frames: preamble/SFD, payload, pad, FCS, inter-frame gap.
- Stamps a sequence number and copy index at a fixed frame offset, so the receiver's majority logic can group copies.
- Output is a byte stream paced by adv_data, feeding the RGMII transmitter.

Parameters:
- REDUNDANCY, 3, frames sent per start (1..7).
- ID_POS, 25, frame byte offset after SFD (0-based) of the sequence byte; copy index goes at ID_POS+1.
- MAX_LEN, 1514, pl_len clamp value.
- IFG_BYTES, 12, idle byte slots after each FCS.

Ports:
- clk125MHz  in  1  sole clock.
- rst  in  1  synchronous reset, active-high.
- adv_data  in  1  byte strobe: one output byte slot per high cycle. Every cycle at 1000Mb, 1/10 at 100Mb.
- start  in  1  one-cycle request to send the buffered payload.
- pl_len  in  11  payload byte count, sampled with start.
- pl_addr  out  11  address of the next payload byte to consume.
- pl_data  in  8  buffer read data. Must be the one-cycle-registered read of pl_addr.
- tx_data  out  8  frame byte.
- tx_en  out  1  frame byte valid.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last IFG of the last copy.
- seq  out  8  sequence number of the current or next burst.

Behaviour:
- Reset values: tx_data=0, tx_en=0, busy=0, done=0, pl_addr=0, seq=0, state=IDLE, copy=0. Reset wins over every other event, including mid-frame: tx_en=0 on the cycle after rst.
- start in IDLE:
  - Latch len = min(pl_len, MAX_LEN); busy=1 next cycle.
  - start while busy is ignored.
  - start and rst in the same cycle: rst wins.
- All state, counter, CRC and tx_data/tx_en updates occur only on adv_data cycles. Outputs are registered and hold their value between adv cycles.
- pl_addr advances on the adv edge that consumes a payload byte, so it is stable for at least 1 cycle before the next adv.
- States, one byte per adv:
  - PRE: 7×0x55, tx_en=1.
  - SFD: 0xD5. Clear CRC to 0xFFFFFFFF and frame offset to 0.
  - PAY: len bytes from pl_data.
  - PAD: 0x00 until frame offset reaches 60. Skipped if len≥60.
  - FCS: 4 bytes.
  - IFG: IFG_BYTES slots with tx_en=0, tx_data=0.
- After IFG:
  - If copy<REDUNDANCY-1: copy++, pl_addr=0, go to PRE.
  - Else: done pulse; seq = seq+1 (mod 256); copy=0; busy=0 (same cycle as done); go to IDLE.
- ID stamping:
  - Offset ID_POS transmits seq; offset ID_POS+1 transmits {5'b0, copy[2:0]}. These replace payload or pad bytes.
  - Both stamps are skipped if their offset ≥ the frame's pre-FCS length.
  - pl_addr still advances over stamped payload bytes.
- CRC-32:
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Covers every byte transmitted from offset 0 through the last pad byte, including stamped values.
  - FCS = ~crc, sent LSB byte first.
- len=0: frame is 60 pad bytes (with stamps) plus FCS.
- Frame on wire = 8 + max(len,60) + 4 bytes with tx_en=1.

Test Plan:
- Basic burst: adv_data=1 continuously, pl_len=64, buffer[i]=i, start. Required: 3 frames of 76 tx_en bytes, each separated by exactly 12 tx_en=0 slots; offsets 25/26 = 0x00/0x00,01,02 across the three frames; each FCS equals a golden CRC-32; done pulses once; seq becomes 1.
- Short frame: pl_len=20. Required: 20 payload bytes then 40×0x00 pad, stamps at offsets 25/26 inside the pad, 72 tx_en bytes per frame, CRC correct over the pad.
- Pacing: adv_data high one cycle in 10. Required: byte sequence identical to the basic-burst case, tx_data changing only on adv cycles, pl_addr stable ≥1 cycle before each consuming adv.
- Ignored start and clamp: start pulsed again mid-burst. Required: no effect. Separately, pl_len=2047. Required: len clamped to 1514, frame of 1526 tx_en bytes.
- Reset mid-frame: rst during the second copy's PAY. Required: tx_en=0, busy=0, seq unchanged, no done pulse. A following start sends a full 3-copy burst with seq=0.
- Wrap: 256 back-to-back bursts. Required: seq goes 255→0, and the stamp of the 257th burst is 0x00.
